// File: rtl/imm_gen_pipe_if.sv
// Decode-stage stream bundle between fetch buffer, immediate generator and register read.
// master = the side feeding instructions and consuming results; slave = the generator.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [31:0]     out_instr;
    logic [15:0]     illegal_count;

    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr, illegal_count
    );

    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr, illegal_count
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Immediate generator: classifies RV32I/RV64I formats, sign-extends the immediate to XLEN, flags illegal opcodes.
// Latency: one cycle from input acceptance to out_valid.
// Backpressure: SKID=1 holds up to two entries with a registered in_ready; SKID=0 is a single pass-through register.
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    imm_gen_pipe_if.slave bus
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [31:0]     instr;
    } ent_t;

    // Each field is assembled as a signed value and widened by the cast, replicating instr[31].
    function automatic ent_t decode(input logic [31:0] i);
        ent_t e;
        e.imm     = '0;
        e.fmt     = FMT_R;
        e.illegal = 1'b0;
        e.instr   = i;
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                e.fmt = FMT_I;
                e.imm = XLEN'($signed(i[31:20]));
            end
            7'b0100011: begin
                e.fmt = FMT_S;
                e.imm = XLEN'($signed({i[31:25], i[11:7]}));
            end
            7'b1100011: begin
                e.fmt = FMT_B;
                e.imm = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                e.fmt = FMT_U;
                e.imm = XLEN'($signed({i[31:12], 12'b0}));
            end
            7'b1101111: begin
                e.fmt = FMT_J;
                e.imm = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            end
            7'b0110011: e.fmt = FMT_R;
            default:    e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    ent_t        main_q;
    ent_t        skid_q;
    ent_t        dec;
    logic        main_vld;
    logic        skid_vld;
    logic        rdy_q;
    logic [15:0] cnt_q;
    logic        in_fire;
    logic        out_fire;

    assign dec = decode(bus.in_instr);

    assign bus.out_valid     = main_vld && !rst;
    assign bus.in_ready      = !rst && (SKID ? rdy_q : (bus.out_ready || !main_vld));
    assign bus.out_imm       = main_q.imm;
    assign bus.out_fmt       = main_q.fmt;
    assign bus.out_illegal   = main_q.illegal;
    assign bus.out_instr     = main_q.instr;
    assign bus.illegal_count = cnt_q;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    // rdy_q mirrors "skid empty" for the coming cycle; it resets high so in_ready rises right after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
            cnt_q    <= '0;
        end else begin
            if (out_fire && main_q.illegal && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (bus.flush) begin
                main_vld <= 1'b0;
                skid_vld <= 1'b0;
                rdy_q    <= 1'b1;
            end else if (out_fire && skid_vld) begin
                // in_ready was low, so no new input can arrive alongside this refill
                main_q   <= skid_q;
                skid_vld <= 1'b0;
                rdy_q    <= 1'b1;
            end else if (in_fire && (!main_vld || out_fire)) begin
                main_q   <= dec;
                main_vld <= 1'b1;
            end else if (in_fire) begin
                skid_q   <= dec;
                skid_vld <= 1'b1;
                rdy_q    <= 1'b0;
            end else if (out_fire) begin
                main_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus; randomized traffic is scored against a queue model.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();

    assign b64.in_valid  = b32.in_valid;
    assign b64.in_instr  = b32.in_instr;
    assign b64.flush     = b32.flush;
    assign b64.out_ready = b32.out_ready;

    imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) dut   (.clk(clk), .rst(rst), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .SKID(1'b1)) dut64 (.clk(clk), .rst(rst), .bus(b64));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    function automatic longint sx(input longint raw, input int w);
        longint half;
        half = longint'(1) << (w - 1);
        return (raw >= half) ? raw - 2 * half : raw;
    endfunction

    // Immediates rebuilt from shifted/masked bit fields and two's-complement arithmetic.
    function automatic exp_t model(input logic [31:0] i);
        exp_t   e;
        longint u;
        longint raw;
        int     w;
        u = {32'd0, i};
        raw = 0;
        w = 0;
        e.instr = i;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        if (i[1:0] != 2'b11) begin
            e.ill = 1'b1;
        end else begin
            case (i[6:0])
                7'h13, 7'h03, 7'h67: begin e.fmt = 3'd1; raw = u >> 20; w = 12; end
                7'h23: begin e.fmt = 3'd2; raw = ((u >> 25) << 5) | ((u >> 7) & 31); w = 12; end
                7'h63: begin
                    e.fmt = 3'd3; w = 13;
                    raw = ((u >> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
                end
                7'h37, 7'h17: begin e.fmt = 3'd4; raw = (u >> 12) << 12; w = 32; end
                7'h6F: begin
                    e.fmt = 3'd5; w = 21;
                    raw = ((u >> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
                end
                7'h33: e.fmt = 3'd0;
                default: e.ill = 1'b1;
            endcase
        end
        e.imm = (w == 0) ? 64'd0 : 64'(sx(raw, w));
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        b32.in_valid = 1'b1;
        b32.in_instr = 32'hFFF00093;
        b32.out_ready = 1'b1;
        b32.flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", b32.in_ready); end
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", b32.out_valid); end
        total++; if (b32.out_imm !== 32'd0 || b64.out_imm !== 64'd0) begin bad++; $display("FAIL reset_imm: got %h/%h want 0", b32.out_imm, b64.out_imm); end
        total++; if (b32.out_fmt !== 3'd0 || b32.out_illegal !== 1'b0 || b32.out_instr !== 32'd0) begin
            bad++; $display("FAIL reset_fields: got fmt=%0d ill=%b instr=%h want 0", b32.out_fmt, b32.out_illegal, b32.out_instr);
        end
        total++; if (b32.illegal_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", b32.illegal_count); end
        tick;
        rst = 1'b0;
        b32.in_valid = 1'b0;
        @(negedge clk);
        total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", b32.in_ready); end
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL reset_release_valid: got %b want 0", b32.out_valid); end
    endtask

    task automatic test_vectors;
        logic [31:0] vi  [5];
        logic [31:0] e32 [5];
        logic [63:0] e64 [5];
        logic [2:0]  ef  [5];
        vi  = '{32'hFFF00093, 32'hFE112E23, 32'hFF9FF06F, 32'h800002B7, 32'h00B50533};
        e32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h80000000, 32'h0};
        e64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFF80000000, 64'h0};
        ef  = '{3'd1, 3'd2, 3'd5, 3'd4, 3'd0};
        for (int k = 0; k < 5; k++) begin
            tick;
            b32.in_valid = 1'b1;
            b32.in_instr = vi[k];
            b32.out_ready = 1'b1;
            @(negedge clk);
            total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL vec%0d_in_ready: got %b want 1", k, b32.in_ready); end
            tick;
            b32.in_valid = 1'b0;
            @(negedge clk);
            total++; if (b32.out_valid !== 1'b1) begin bad++; $display("FAIL vec%0d_valid: got %b want 1", k, b32.out_valid); end
            total++; if (b32.out_imm !== e32[k]) begin bad++; $display("FAIL vec%0d_imm32: got %h want %h", k, b32.out_imm, e32[k]); end
            total++; if (b64.out_imm !== e64[k]) begin bad++; $display("FAIL vec%0d_imm64: got %h want %h", k, b64.out_imm, e64[k]); end
            total++; if (b32.out_fmt !== ef[k] || b32.out_illegal !== 1'b0 || b32.out_instr !== vi[k]) begin
                bad++; $display("FAIL vec%0d_fields: got fmt=%0d ill=%b instr=%h want fmt=%0d ill=0 instr=%h",
                                k, b32.out_fmt, b32.out_illegal, b32.out_instr, ef[k], vi[k]);
            end
        end
        tick;
    endtask

    task automatic test_backpressure;
        logic [31:0] v [4];
        int si, di, cyc;
        v = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
        si = 0; di = 0; cyc = 0;
        while (di < 4 && cyc < 40) begin
            tick;
            b32.in_valid = (si < 4);
            b32.in_instr = (si < 4) ? v[si] : 32'h0;
            b32.out_ready = (cyc >= 3);
            @(negedge clk);
            if (cyc == 2) begin
                total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready: got %b want 0", b32.in_ready); end
                total++; if (si != 2) begin bad++; $display("FAIL bp_accepts: got %0d want 2", si); end
            end
            if (cyc == 3) begin
                total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL bp_drain_ready: got %b want 0", b32.in_ready); end
            end
            if (cyc == 4) begin
                total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_rise: got %b want 1", b32.in_ready); end
            end
            if (b32.out_valid && b32.out_ready) begin
                total++; if (b32.out_instr !== v[di] || b32.out_imm !== 32'(di + 1)) begin
                    bad++; $display("FAIL bp_order%0d: got %h/%h want %h/%h", di, b32.out_instr, b32.out_imm, v[di], di + 1);
                end
                di++;
            end
            if (b32.in_valid && b32.in_ready) si++;
            cyc++;
        end
        total++; if (di != 4) begin bad++; $display("FAIL bp_delivered: got %0d want 4", di); end
        tick;
        b32.in_valid = 1'b0;
        @(negedge clk);
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup: got %b want 0", b32.out_valid); end
    endtask

    task automatic test_illegal_flush;
        tick;
        b32.in_valid = 1'b1; b32.in_instr = 32'h0; b32.out_ready = 1'b1; b32.flush = 1'b0;
        tick;
        @(negedge clk);
        total++; if (b32.out_valid !== 1'b1 || b32.out_illegal !== 1'b1 || b32.out_fmt !== 3'd0 || b32.out_imm !== 32'd0) begin
            bad++; $display("FAIL ill_fields: got v=%b ill=%b fmt=%0d imm=%h want 1 1 0 0", b32.out_valid, b32.out_illegal, b32.out_fmt, b32.out_imm);
        end
        tick;
        b32.in_valid = 1'b0;
        @(negedge clk);
        total++; if (b32.illegal_count !== 16'd1) begin bad++; $display("FAIL ill_count1: got %0d want 1", b32.illegal_count); end
        tick;
        @(negedge clk);
        total++; if (b32.illegal_count !== 16'd2 || b32.out_valid !== 1'b0) begin
            bad++; $display("FAIL ill_count2: got %0d v=%b want 2 v=0", b32.illegal_count, b32.out_valid);
        end
        tick;
        b32.out_ready = 1'b0; b32.in_valid = 1'b1; b32.in_instr = 32'h0;
        tick;
        b32.in_instr = 32'h00000013;
        tick;
        b32.in_instr = 32'h0; b32.flush = 1'b1;
        @(negedge clk);
        total++; if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1) begin
            bad++; $display("FAIL flush_prefull: got rdy=%b v=%b want 0 1", b32.in_ready, b32.out_valid);
        end
        tick;
        b32.flush = 1'b0; b32.in_valid = 1'b0;
        @(negedge clk);
        total++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_empty: got v=%b rdy=%b want 0 1", b32.out_valid, b32.in_ready);
        end
        tick;
        b32.out_ready = 1'b1;
        @(negedge clk);
        total++; if (b32.out_valid !== 1'b0 || b32.illegal_count !== 16'd2) begin
            bad++; $display("FAIL flush_nothing: got v=%b cnt=%0d want 0 2", b32.out_valid, b32.illegal_count);
        end
        tick;
        b32.in_valid = 1'b1; b32.in_instr = 32'h0; b32.flush = 1'b1;
        tick;
        b32.in_valid = 1'b0; b32.flush = 1'b0;
        @(negedge clk);
        total++; if (b32.out_valid !== 1'b0 || b32.illegal_count !== 16'd2) begin
            bad++; $display("FAIL flush_discard_in: got v=%b cnt=%0d want 0 2", b32.out_valid, b32.illegal_count);
        end
    endtask

    task automatic test_random;
        exp_t        q[$];
        exp_t        h;
        logic [15:0] cnt_m;
        logic [6:0]  ops [11];
        logic [31:0] r;
        logic [31:0] r2;
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00, 7'h7F};
        rst = 1'b1;
        tick;
        rst = 1'b0;
        cnt_m = 16'd0;
        for (int c = 0; c < 3000; c++) begin
            tick;
            r  = $urandom;
            r2 = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            b32.in_valid = ($urandom_range(0, 3) != 0);
            b32.in_instr = (r2[3:0] == 4'd0) ? r : {r[31:7], ops[$urandom_range(0, 10)]};
            b32.out_ready = ($urandom_range(0, 2) != 0);
            b32.flush = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            if (rst) begin
                total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL rnd_rst_ready c%0d: got %b want 0", c, b32.in_ready); end
                q.delete();
                cnt_m = 16'd0;
            end else begin
                total++; if (b32.out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid c%0d: got %b want %b", c, b32.out_valid, q.size() != 0); end
                total++; if (b32.in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, b32.in_ready, q.size() < 2); end
                total++; if (b32.illegal_count !== cnt_m) begin bad++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, b32.illegal_count, cnt_m); end
                if (b32.out_valid && b32.out_ready && q.size() != 0) begin
                    h = q.pop_front();
                    total++;
                    if (b32.out_instr !== h.instr || b32.out_imm !== h.imm[31:0] || b64.out_imm !== h.imm ||
                        b32.out_fmt !== h.fmt || b32.out_illegal !== h.ill || b64.out_fmt !== h.fmt) begin
                        bad++;
                        $display("FAIL rnd_data c%0d: got instr=%h imm=%h/%h fmt=%0d ill=%b want instr=%h imm=%h fmt=%0d ill=%b",
                                 c, b32.out_instr, b32.out_imm, b64.out_imm, b32.out_fmt, b32.out_illegal, h.instr, h.imm, h.fmt, h.ill);
                    end
                    if (h.ill && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
                end
                if (b32.flush) q.delete();
                else if (b32.in_valid && b32.in_ready) q.push_back(model(b32.in_instr));
            end
        end
        tick;
        rst = 1'b0; b32.in_valid = 1'b0; b32.flush = 1'b0;
    endtask

    task automatic test_saturate;
        int d, cyc;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        b32.in_valid = 1'b1; b32.in_instr = 32'h0; b32.out_ready = 1'b1; b32.flush = 1'b0;
        d = 0; cyc = 0;
        while (d < 65538 && cyc < 70000) begin
            @(negedge clk);
            if (d == 65534) begin
                total++; if (b32.illegal_count !== 16'hFFFE) begin bad++; $display("FAIL sat_below: got %h want fffe", b32.illegal_count); end
            end
            if (d == 65537) begin
                total++; if (b32.illegal_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want ffff", b32.illegal_count); end
            end
            if (b32.out_valid && b32.out_ready) d++;
            cyc++;
        end
        total++; if (d != 65538) begin bad++; $display("FAIL sat_deliveries: got %0d want 65538", d); end
        tick;
        b32.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_illegal_flush();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
